// File: rtl/roll_scheduler_if.sv
// ============================================================================
// Module      : roll_scheduler_if
// Description : Handshake/data bundle between the roll scheduler and the
//               random-number datapath / hex display path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface roll_scheduler_if #(
    parameter int DATA_W = 4
);
    logic              i_start;
    logic              i_show_last;
    logic [DATA_W-1:0] i_value;
    logic              o_step;
    logic [DATA_W-1:0] o_display;
    logic              o_changing;
    logic              o_done;

    modport master (
        output i_start, i_show_last, i_value,
        input  o_step, o_display, o_changing, o_done
    );

    modport slave (
        input  i_start, i_show_last, i_value,
        output o_step, o_display, o_changing, o_done
    );
endinterface

`default_nettype wire

// File: rtl/roll_scheduler.sv
// ============================================================================
// Module      : roll_scheduler
// Description : Turns a start pulse into geometrically slowing advance strobes,
//               latches the settled value and selects the display source.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module roll_scheduler #(
    parameter int INIT_INTERVAL = 2500000,
    parameter int GROWTH_SHIFT  = 3,
    parameter int NUM_STEPS     = 32,
    parameter int CNT_W         = 32,
    parameter int DATA_W        = 4
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst,
    roll_scheduler_if.slave  bus
);

    localparam int                  c_STEP_W = $clog2(NUM_STEPS + 1);
    localparam logic [CNT_W-1:0]    c_INIT   = CNT_W'(INIT_INTERVAL);
    localparam logic [c_STEP_W-1:0] c_LAST   = c_STEP_W'(NUM_STEPS - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_LATCH = 2'd2;

    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_interval;
    logic [c_STEP_W-1:0] r_steps;
    logic [DATA_W-1:0]   r_cur;
    logic [DATA_W-1:0]   r_last;

    logic                w_step;
    logic                w_changing;
    logic [CNT_W:0]      w_grow;
    logic [CNT_W-1:0]    w_next_interval;

    assign w_step     = (r_state == c_RUN) && (r_cnt == (r_interval - CNT_W'(1)));
    assign w_changing = (r_state != c_IDLE);

    // One extra bit catches the carry so the interval saturates instead of wrapping.
    assign w_grow          = {1'b0, r_interval} + ({1'b0, r_interval} >> GROWTH_SHIFT);
    assign w_next_interval = w_grow[CNT_W] ? {CNT_W{1'b1}} : w_grow[CNT_W-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_interval <= c_INIT;
            r_steps    <= '0;
            r_cur      <= '0;
            r_last     <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.i_start) begin
                        r_state    <= c_RUN;
                        r_cnt      <= '0;
                        r_interval <= c_INIT;
                        r_steps    <= '0;
                    end
                end
                c_RUN: begin
                    // A restart outranks both the step bookkeeping and the move to LATCH.
                    if (bus.i_start) begin
                        r_cnt      <= '0;
                        r_interval <= c_INIT;
                        r_steps    <= '0;
                    end else if (w_step) begin
                        r_cnt      <= '0;
                        r_steps    <= r_steps + c_STEP_W'(1);
                        r_interval <= w_next_interval;
                        if (r_steps == c_LAST) begin
                            r_state <= c_LATCH;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                c_LATCH: begin
                    r_last  <= r_cur;
                    r_cur   <= bus.i_value;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.o_step     = w_step;
    assign bus.o_changing = w_changing;
    assign bus.o_done     = (r_state == c_LATCH);
    assign bus.o_display  = bus.i_show_last ? r_last : (w_changing ? bus.i_value : r_cur);

endmodule

`default_nettype wire

// File: tb/tb_roll_scheduler.sv
// ============================================================================
// Module      : tb_roll_scheduler
// Description : Self-checking bench for roll_scheduler, two parameter sets,
//               directed scenarios followed by randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_roll_scheduler;

    typedef struct {
        bit         active;
        int         ofs;
        logic [3:0] cur;
        logic [3:0] last;
    } model_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b, show_last;
    logic [3:0] value;
    bit         check_en = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         sched [2][3];
    int         total [2];
    model_t     ma, mb;
    int         step_q[$];
    int         done_q[$];
    int         chg_n;

    always #5 clk = ~clk;

    roll_scheduler_if #(.DATA_W(4)) bus_a ();
    roll_scheduler_if #(.DATA_W(4)) bus_b ();

    assign bus_a.i_start     = start_a;
    assign bus_a.i_show_last = show_last;
    assign bus_a.i_value     = value;
    assign bus_b.i_start     = start_b;
    assign bus_b.i_show_last = show_last;
    assign bus_b.i_value     = value;

    roll_scheduler #(
        .INIT_INTERVAL(4), .GROWTH_SHIFT(1), .NUM_STEPS(3), .CNT_W(32), .DATA_W(4)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .bus(bus_a)
    );

    roll_scheduler #(
        .INIT_INTERVAL(12), .GROWTH_SHIFT(0), .NUM_STEPS(3), .CNT_W(4), .DATA_W(4)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .bus(bus_b)
    );

    // Reference: a roll is "active" with an offset counted from the start edge;
    // steps fire at cumulative interval sums, the latch one cycle after the last.
    function automatic model_t next_model(model_t m, int tot, bit r, bit s, logic [3:0] v);
        model_t n;
        n = m;
        if (r) begin
            n.active = 1'b0; n.ofs = 0; n.cur = 4'h0; n.last = 4'h0;
        end else if (m.active && m.ofs == tot + 1) begin
            n.last = m.cur; n.cur = v; n.active = 1'b0;
        end else if (s) begin
            n.active = 1'b1; n.ofs = 1;
        end else if (m.active) begin
            n.ofs = m.ofs + 1;
        end
        return n;
    endfunction

    function automatic bit exp_step(int sel, model_t m);
        for (int i = 0; i < 3; i++)
            if (m.active && m.ofs == sched[sel][i]) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        ma <= next_model(ma, total[0], rst, start_a, value);
        mb <= next_model(mb, total[1], rst, start_b, value);
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_dut(string nm, int sel, model_t m, logic st, logic dn, logic ch,
                             logic [3:0] disp);
        logic [3:0] exp_disp;
        exp_disp = show_last ? m.last : (m.active ? value : m.cur);
        chk({nm, " step"},     32'(st), 32'(exp_step(sel, m)));
        chk({nm, " done"},     32'(dn), 32'(m.active && m.ofs == total[sel] + 1));
        chk({nm, " changing"}, 32'(ch), 32'(m.active));
        chk({nm, " display"},  32'(disp), 32'(exp_disp));
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check_dut("A", 0, ma, bus_a.o_step, bus_a.o_done, bus_a.o_changing, bus_a.o_display);
            check_dut("B", 1, mb, bus_b.o_step, bus_b.o_done, bus_b.o_changing, bus_b.o_display);
        end
    end

    function automatic int qget(int i);
        return (i < step_q.size()) ? step_q[i] : -1;
    endfunction

    task automatic kick(int sel);
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
    endtask

    // Runs cycles 1..ncyc after a kick, optionally pulsing start or reset in one cycle.
    task automatic run(int sel, int ncyc, int start_at, int rst_at);
        step_q.delete(); done_q.delete(); chg_n = 0;
        for (int k = 1; k <= ncyc; k++) begin
            if (sel == 0) start_a = (k == start_at); else start_b = (k == start_at);
            rst = (k == rst_at);
            @(negedge clk);
            if ((sel == 0) ? bus_a.o_step : bus_b.o_step) step_q.push_back(k);
            if ((sel == 0) ? bus_a.o_done : bus_b.o_done) done_q.push_back(k);
            if ((sel == 0) ? bus_a.o_changing : bus_b.o_changing) chg_n++;
            @(posedge clk); #1;
        end
        start_a = 1'b0; start_b = 1'b0; rst = 1'b0;
    endtask

    initial begin
        for (int sel = 0; sel < 2; sel++) begin
            longint iv, maxv, cum;
            int     sh;
            iv   = (sel == 0) ? 4 : 12;
            sh   = (sel == 0) ? 1 : 0;
            maxv = (sel == 0) ? ((longint'(1) << 32) - 1) : ((longint'(1) << 4) - 1);
            cum  = 0;
            for (int i = 0; i < 3; i++) begin
                cum = cum + iv;
                sched[sel][i] = int'(cum);
                iv = iv + (iv >> sh);
                if (iv > maxv) iv = maxv;
            end
            total[sel] = sched[sel][2];
        end

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; show_last = 1'b0; value = 4'h7;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; check_en = 1'b1;

        @(negedge clk);
        chk("reset A changing", 32'(bus_a.o_changing), 0);
        chk("reset A display",  32'(bus_a.o_display), 0);
        chk("reset B step",     32'(bus_b.o_step), 0);
        @(posedge clk); #1;

        // Roll 1 settles on 7
        kick(0); run(0, 21, 0, 0);
        chk("roll1 step count", step_q.size(), 3);
        chk("roll1 step1", qget(0), 4);
        chk("roll1 step2", qget(1), 10);
        chk("roll1 step3", qget(2), 19);
        chk("roll1 done count", done_q.size(), 1);
        chk("roll1 done ofs", (done_q.size() > 0) ? done_q[0] : -1, 20);
        chk("roll1 changing cycles", chg_n, 20);

        // Roll 2 settles on A, history keeps 7
        value = 4'hA;
        kick(0); run(0, 21, 0, 0);
        show_last = 1'b1;
        @(negedge clk); chk("history last", 32'(bus_a.o_display), 32'h7);
        @(posedge clk); #1; show_last = 1'b0;
        @(negedge clk); chk("history cur", 32'(bus_a.o_display), 32'hA);
        @(posedge clk); #1;

        // Restart at offset 8
        kick(0); run(0, 30, 8, 0);
        chk("restart step count", step_q.size(), 4);
        chk("restart step after", qget(1), 12);
        chk("restart done count", done_q.size(), 1);
        chk("restart done ofs", (done_q.size() > 0) ? done_q[0] : -1, 28);

        // Start during the latch cycle is ignored
        kick(0); run(0, 45, 20, 0);
        chk("latch-start steps", step_q.size(), 3);
        chk("latch-start done count", done_q.size(), 1);
        chk("latch-start changing cycles", chg_n, 20);

        // Reset at offset 11
        kick(0); run(0, 30, 0, 11);
        chk("rst steps", step_q.size(), 2);
        chk("rst done count", done_q.size(), 0);
        chk("rst changing cycles", chg_n, 11);
        show_last = 1'b1;
        @(negedge clk); chk("rst last cleared", 32'(bus_a.o_display), 0);
        @(posedge clk); #1; show_last = 1'b0;
        @(negedge clk); chk("rst cur cleared", 32'(bus_a.o_display), 0);
        @(posedge clk); #1;

        // Saturating interval growth
        kick(1); run(1, 45, 0, 0);
        chk("sat step count", step_q.size(), 3);
        chk("sat step1", qget(0), 12);
        chk("sat step2", qget(1), 27);
        chk("sat step3", qget(2), 42);
        chk("sat done ofs", (done_q.size() > 0) ? done_q[0] : -1, 43);

        // Randomized traffic against the reference
        for (int c = 0; c < 4000; c++) begin
            start_a   = ($urandom_range(0, 39) == 0);
            start_b   = ($urandom_range(0, 79) == 0);
            rst       = ($urandom_range(0, 599) == 0);
            show_last = 1'($urandom_range(0, 1));
            value     = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
        end
        start_a = 1'b0; start_b = 1'b0; rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/roll_scheduler.md
Name: roll_scheduler

Overview:
Sequencing controller for the random-number datapath. It turns a one-cycle start pulse into a train of advance strobes whose spacing grows geometrically, giving a "slowing roll" effect on the hex display. After the final strobe it latches the settled value and keeps a one-deep history. It also selects what drives the seven-segment decoder: live value, current result, or last result.

Parameters:
INIT_INTERVAL, 2500000, cycles between start and the first o_step; must be >= 2
GROWTH_SHIFT, 3, after each step: interval <= interval + (interval >> GROWTH_SHIFT)
NUM_STEPS, 32, number of o_step pulses per roll; must be >= 1
CNT_W, 32, width of the interval and cycle counters
DATA_W, 4, width of the datapath value

Ports:
i_clk  in  1  system clock; all logic on its rising edge
i_rst  in  1  synchronous reset, active-high
i_start  in  1  one-cycle pulse (debounced key-down) that begins or restarts a roll
i_show_last  in  1  level; 1 selects the previous result on o_display
i_value  in  DATA_W  current datapath output; it updates on the edge that closes an o_step cycle
o_step  out  1  one-cycle advance strobe to the datapath
o_display  out  DATA_W  value routed to the hex decoder
o_changing  out  1  high while a roll is in progress (drives LED)
o_done  out  1  one-cycle pulse in the latch cycle

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous, active-high, and takes priority over everything else.
- Reset values: state=IDLE, cnt=0, interval=INIT_INTERVAL, steps=0, cur_result=0, last_result=0. All outputs are 0.
- States:
  - IDLE: i_start -> RUN, with cnt=0, interval=INIT_INTERVAL, steps=0.
  - RUN: each cycle, cnt++.
    - When cnt==interval-1: o_step=1 that cycle, cnt<=0, steps++, interval updated by the growth rule.
    - If the step just issued is the NUM_STEPS-th: go to LATCH instead of continuing.
  - LATCH (exactly 1 cycle): o_done=1. At the closing edge: last_result<=cur_result, cur_result<=i_value, state<=IDLE.
- Outputs are Moore-decoded from registers; no combinational path from i_start.
  - o_step = RUN && cnt==interval-1.
  - o_changing = (state != IDLE).
  - o_display = i_show_last ? last_result : (o_changing ? i_value : cur_result).
- Latency: start is sampled at edge E0. Step k fires in the cycle ending at edge E0 + sum(interval_0..interval_k-1). LATCH is the following cycle.
- Arithmetic: the growth rule is computed in CNT_W+1 bits and saturates at 2^CNT_W-1. It never wraps.
- Restart: i_start in RUN restarts the roll (cnt, interval and steps reinitialised). No result is committed and no o_done pulse is issued. If i_start coincides with an o_step cycle, the o_step still asserts and the restart wins.
- i_start in LATCH is ignored; the latch completes normally.
- i_show_last only affects o_display and may toggle at any time, including mid-roll.
- Reset mid-roll: returns to IDLE next edge, clears both results, emits no o_done.

Test Plan:
- Params INIT_INTERVAL=4, GROWTH_SHIFT=1, NUM_STEPS=3; start at E0 -> o_step at cycle offsets 4, 10, 19 (intervals 4, 6, 9); o_done at offset 20; o_changing high offsets 1..20.
- Same params, i_value=0x7 in the LATCH cycle, then a second roll ending with 0xA -> cur_result=0xA, last_result=0x7; i_show_last=1 shows 7, i_show_last=0 shows A.
- Start pulse again at offset 8 of a roll -> no o_done; next o_step at offset 8+4=12; roll completes 20 cycles after the restart.
- i_start asserted during the LATCH cycle -> ignored; one o_done; state IDLE afterwards; no new o_step.
- i_rst asserted at offset 11 -> all outputs 0 next cycle, results cleared, no o_step or o_done until the next start.
- CNT_W=4, INIT_INTERVAL=12, GROWTH_SHIFT=0, NUM_STEPS=3 -> intervals 12, 15, 15 (saturated); o_step at offsets 12, 27, 42.
